// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and constants for the game score keeper
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [15:0] SCORE_MAX_BCD  = 16'h9999;
  localparam int          LEVEL_STEP_DEF = 10;
  localparam int          MAX_LEVEL_DEF  = 7;

endpackage

// File: rtl/game_score_keeper_if.sv
// rtl/game_score_keeper_if.sv - control inputs and score/status outputs of the score keeper
interface game_score_keeper_if;

  logic        start;
  logic        pause;
  logic        score;
  logic        end_game;
  logic [1:0]  state;
  logic        running;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic [2:0]  level;
  logic        over_flag;

  // Drives the game events and observes the status
  modport master (
    output start, pause, score, end_game,
    input  state, running, score_bcd, high_bcd, level, over_flag
  );

  // The score keeper itself
  modport slave (
    input  start, pause, score, end_game,
    output state, running, score_bcd, high_bcd, level, over_flag
  );

endinterface

// File: rtl/bcd_counter4.sv
// rtl/bcd_counter4.sv - four-digit BCD up-counter with synchronous clear, saturating at 9999
module bcd_counter4
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q,
  output logic        sat
);

  logic [15:0] q_inc;
  logic        carry;

  // Ripple a +1 through the digits; a 9 rolls to 0 and passes the carry on
  always_comb begin
    q_inc = q;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (q[i*4 +: 4] == 4'd9) begin
          q_inc[i*4 +: 4] = 4'd0;
        end else begin
          q_inc[i*4 +: 4] = q[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign sat = (q == SCORE_MAX_BCD);

  // Count register: clear beats increment, increments at 9999 are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 16'h0000;
    end else if (clr) begin
      q <= 16'h0000;
    end else if (inc && !sat) begin
      q <= q_inc;
    end
  end

endmodule

// File: rtl/game_score_keeper.sv
// rtl/game_score_keeper.sv - game state machine with BCD score, high score and difficulty level
module game_score_keeper
  import game_pkg::*;
#(
  parameter int LEVEL_STEP = LEVEL_STEP_DEF,
  parameter int MAX_LEVEL  = MAX_LEVEL_DEF
) (
  input logic               clk,
  input logic               rst,
  game_score_keeper_if.slave bus
);

  state_t      state_q, state_n;
  logic        score_d;
  logic        score_edge;
  logic        clr;
  logic        inc;
  logic        adv;
  logic        high_load;
  logic        sat;
  logic [15:0] score_q;
  logic [15:0] high_q;
  logic [3:0]  pil_q;
  logic [2:0]  level_q;

  assign score_edge = bus.score & ~score_d;
  // A point only advances the level when the score counter actually moved
  assign adv = inc & ~sat;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next state and per-cycle control; end_game beats pause and scoring, start beats pause
  always_comb begin
    state_n   = state_q;
    clr       = 1'b0;
    inc       = 1'b0;
    high_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_n = PLAY;
          clr     = 1'b1;
        end
      end
      PLAY: begin
        if (bus.end_game) begin
          state_n   = OVER;
          high_load = (score_q > high_q);
        end else begin
          if (bus.pause) state_n = PAUSE;
          inc = score_edge;
        end
      end
      PAUSE: begin
        if (bus.start) begin
          state_n = PLAY;
          clr     = 1'b1;
        end else if (bus.pause) begin
          state_n = PLAY;
        end
      end
      OVER: begin
        if (bus.start) begin
          state_n = PLAY;
          clr     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Score level history, tracked in every state so held levels never count on resume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) score_d <= 1'b0;
    else     score_d <= bus.score;
  end

  // Points-in-level counter and saturating difficulty level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pil_q   <= 4'd0;
      level_q <= 3'd0;
    end else if (clr) begin
      pil_q   <= 4'd0;
      level_q <= 3'd0;
    end else if (adv) begin
      if (pil_q == 4'(LEVEL_STEP - 1)) begin
        pil_q <= 4'd0;
        if (level_q != 3'(MAX_LEVEL)) level_q <= level_q + 3'd1;
      end else begin
        pil_q <= pil_q + 4'd1;
      end
    end
  end

  // Best score, captured from the pre-increment score on the way into OVER
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            high_q <= 16'h0000;
    else if (high_load) high_q <= score_q;
  end

  bcd_counter4 u_score (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (inc),
    .q   (score_q),
    .sat (sat)
  );

  assign bus.state     = state_q;
  assign bus.running   = (state_q == PLAY);
  assign bus.over_flag = (state_q == OVER);
  assign bus.score_bcd = score_q;
  assign bus.high_bcd  = high_q;
  assign bus.level     = level_q;

endmodule

// File: doc/game_score_keeper.md
# game_score_keeper

Downstream of the collision stage: consumes the per-cycle `score` and `end_game` levels and runs the game-level state machine. It maintains a 4-digit BCD score and a high score, a difficulty level that drives the object speed, and the `running` enable that gates object and car motion. Its outputs feed the 7-segment display driver and the object generator.

## Interface
Parameters:
- `LEVEL_STEP`, 10: points per difficulty level increment (1..15).
- `MAX_LEVEL`, 7: level saturation value (≤7).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  debounced single-cycle start/restart pulse.
- `pause`  in  1  debounced single-cycle pause toggle pulse.
- `score`  in  1  collision stage score level; held high while a scoring object overlaps the car band.
- `end_game`  in  1  collision stage crash level.
- `state`  out  2  current FSM state encoding.
- `running`  out  1  high only in PLAY; gates object and car motion.
- `score_bcd`  out  16  current score, four BCD digits, `[15:12]` = thousands.
- `high_bcd`  out  16  best score since reset, BCD.
- `level`  out  3  difficulty level, 0..`MAX_LEVEL`.
- `over_flag`  out  1  high in OVER; drives the "game over" display.

## Operation
- **States:** IDLE=0, PLAY=1, PAUSE=2, OVER=3.
- **IDLE:**
  - `start` → PLAY.
  - `score_bcd` and `level` are cleared on the transition.
- **PLAY:**
  - A rising edge of `score` (score=1, score_d=0) increments `score_bcd` by 1.
  - A score edge also advances the points-in-level counter. When that counter reaches `LEVEL_STEP`-1, it wraps to 0 and `level` increments, saturating at `MAX_LEVEL`.
  - `end_game`=1 → OVER.
  - `pause` → PAUSE.
  - `start` is ignored.
- **PAUSE:**
  - `pause` → PLAY.
  - `start` → PLAY with score, level and points-in-level counter cleared.
  - `score` and `end_game` are ignored.
- **OVER:**
  - On entry, `high_bcd` ← `score_bcd` if `score_bcd` > `high_bcd`.
  - `start` → PLAY with score, level and points-in-level counter cleared; `high_bcd` is kept.
  - `pause` is ignored.
- **Edge detection:**
  - `score_d` is a register updated every cycle in every state.
  - A score level still high on resume from PAUSE, or on restart, is not counted.
- **BCD arithmetic:**
  - A digit of 9 rolls to 0 and carries.
  - At 9999 the score saturates: increments are dropped and neither `level` nor the points-in-level counter changes.
  - `high_bcd` compare is a plain 16-bit unsigned compare of the packed BCD vectors; this is valid because BCD ordering matches binary ordering.
- **Simultaneous events:**
  - `end_game` and a score edge in the same PLAY cycle: `end_game` wins, the point is not counted, and `high_bcd` uses the pre-increment score.
  - `pause` and `end_game` in the same PLAY cycle: `end_game` wins.
  - `start` and `pause` in the same PAUSE cycle: `start` wins.
- **Reset**, including mid-game: state=IDLE, `score_bcd`=0, `high_bcd`=0, `level`=0, points-in-level counter=0, `score_d`=0, `running`=0, `over_flag`=0.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Score latency: rising edge of `score` sampled at edge N → `score_bcd` and `level` updated after edge N.
- `end_game` sampled at edge N → `state`=OVER, `running`=0, `over_flag`=1 and `high_bcd` updated, all after edge N.
- `start` or `pause` pulses take effect at the sampling edge; `running` follows state with no extra delay.
- A score level held for K cycles yields exactly one increment. Two score pulses separated by one low cycle yield two increments.

## Structure
- **Shared package `game_pkg`:**
  - state encoding constants (IDLE, PLAY, PAUSE, OVER);
  - `SCORE_MAX_BCD` = 16'h9999;
  - default `LEVEL_STEP` and `MAX_LEVEL` values.
- **Sub-module `bcd_counter4`:**
  - Ports: `clk`, `rst`, `clr`, `inc`; output `q[15:0]`; flag `sat`.
  - Synchronous clear takes priority over `inc`; saturates at 9999.
  - Instantiated once, for `score_bcd`.
- The top level holds the FSM, edge detector, points-in-level counter, level register and high-score register.

## Test plan
1. **Reset mid-PLAY** with score 0042, high 0100: assert `rst` → all outputs 0, state IDLE, immediately (asynchronous).
2. **Start and held score:** `start`, then `score` high 5 cycles, low 2, high 3 → `score_bcd`=0002, `running`=1, `level`=0.
3. **Level and BCD carry:** 25 score pulses with `LEVEL_STEP`=10 → `score_bcd`=0x0025, `level`=2. Preload 0099 then one pulse → 0x0100.
4. **Crash and high score:** `end_game` with score 0037 and high 0020 → OVER, `high_bcd`=0037, `over_flag`=1. Restart, crash at 0010 → `high_bcd` stays 0037.
5. **Pause:** `pause` in PLAY, then `score` and `end_game` pulses, then `pause` while `score` is still high → score unchanged, state PLAY, no increment until the next rising edge.
6. **Boundaries:** with score 9999, a further pulse → score stays 9999 and `level` is unchanged. `end_game` plus a score rising edge in the same cycle at 0005 → OVER, score 0005, `high_bcd`=0005.
